mmio_uart_tx: RTL and testbench

MMIO_UART_TX -- requirements
Module: mmio_uart_tx

---
 rtl/mmio_uart_tx.sv | 180 ++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 472 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with a one-byte holding buffer.
// DATA   at BASE_ADDR   : store queues a byte, load returns the last accepted byte.
// STATUS at BASE_ADDR+4 : {29'b0, ovr, hold_full, tx_busy}; a load clears ovr.
module mmio_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_00F0
) (
    input  logic        clk_t,
    input  logic        rst_t,
    input  logic        mem_wr_en,
    input  logic        mem_rd_en,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        tx_out,
    output logic        tx_busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam logic [31:0] DATA_ADDR   = BASE_ADDR;
    localparam logic [31:0] STATUS_ADDR = BASE_ADDR + 32'd4;
    localparam logic [15:0] BIT_LAST    = 16'(CLKS_PER_BIT - 1);

    logic [1:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  hold_q, hold_d;
    logic        hold_full_q, hold_full_d;
    logic        ovr_q, ovr_d;
    logic [31:0] rdata_q, rdata_d;
    logic        tx_q, tx_d;

    logic        load_shift;
    logic        bit_done;
    logic        wr_data;
    logic        rd_data;
    logic        rd_status;
    logic        unused_wdata;

    assign unused_wdata = ^mem_wdata[31:8];

    assign tx_busy   = (state_q != ST_IDLE);
    assign tx_out    = tx_q;
    assign mem_rdata = rdata_q;

    // Frame sequencer: baud counter, bit index and shift register.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        load_shift = 1'b0;
        bit_done   = (cnt_q == BIT_LAST);
        case (state_q)
            ST_IDLE: begin
                if (hold_full_q) begin
                    load_shift = 1'b1;
                    shift_d    = hold_q;
                    cnt_d      = '0;
                    idx_d      = '0;
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                if (bit_done) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = ST_DATA;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    cnt_d   = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (idx_q == 3'd7) begin
                        idx_d   = '0;
                        state_d = ST_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_STOP: begin
                if (bit_done) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                cnt_d   = '0;
                idx_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Line level follows the current state, so the output lags the state by one clock.
    always_comb begin
        tx_d = 1'b1;
        case (state_q)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shift_q[0];
            default:  tx_d = 1'b1;
        endcase
    end

    // Register window: holding buffer, sticky overrun, registered load data.
    always_comb begin
        wr_data     = mem_wr_en && (mem_addr == DATA_ADDR);
        rd_data     = mem_rd_en && (mem_addr == DATA_ADDR);
        rd_status   = mem_rd_en && (mem_addr == STATUS_ADDR);
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        ovr_d       = ovr_q;
        rdata_d     = rdata_q;

        if (load_shift) begin
            hold_full_d = 1'b0;
        end
        // The buffer being drained this cycle counts as free for a same-cycle store.
        if (wr_data && (!hold_full_q || load_shift)) begin
            hold_d      = mem_wdata[7:0];
            hold_full_d = 1'b1;
        end
        // Clear-on-read first so that a same-cycle overrun still leaves ovr set.
        if (rd_status) begin
            ovr_d = 1'b0;
        end
        if (wr_data && hold_full_q && !load_shift) begin
            ovr_d = 1'b1;
        end

        if (mem_rd_en) begin
            if (rd_status) begin
                rdata_d = {29'b0, ovr_q, hold_full_q, tx_busy};
            end else if (rd_data) begin
                rdata_d = {24'b0, hold_q};
            end else begin
                rdata_d = '0;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_t) begin
        if (!rst_t) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            hold_q      <= 8'h00;
            hold_full_q <= 1'b0;
            ovr_q       <= 1'b0;
            rdata_q     <= '0;
            tx_q        <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            ovr_q       <= ovr_d;
            rdata_q     <= rdata_d;
            tx_q        <= tx_d;
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: randomized and directed bench for mmio_uart_tx with a
// timeline-level reference model (buffer occupancy plus frame start edges).
module tb_mmio_uart_tx;

    localparam int          CPB    = 4;
    localparam int          FRAME  = 10 * CPB;
    localparam int          MAXC   = 4096;
    localparam logic [31:0] BASE   = 32'h0000_00F0;
    localparam logic [31:0] A_DATA = BASE;
    localparam logic [31:0] A_STAT = BASE + 32'd4;

    logic        clk_t;
    logic        rst_t;
    logic        mem_wr_en;
    logic        mem_rd_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        tx_out;
    logic        tx_busy;

    int n_checks = 0;
    int n_fail   = 0;

    // edge counter: index of the next rising edge
    int t = 0;
    logic line_log [0:MAXC-1];
    logic busy_log [0:MAXC-1];

    // reference model
    logic       m_hold_valid = 1'b0;
    logic [7:0] m_hold_byte  = 8'h00;
    logic [7:0] m_last       = 8'h00;
    logic       m_ovr        = 1'b0;
    int         m_next_load  = 0;
    int         load_edge [$];
    int         load_end  [$];
    logic [7:0] load_byte [$];

    int         dec_start [$];
    logic [7:0] dec_byte  [$];

    mmio_uart_tx #(.CLKS_PER_BIT(CPB), .BASE_ADDR(BASE)) dut (
        .clk_t    (clk_t),
        .rst_t    (rst_t),
        .mem_wr_en(mem_wr_en),
        .mem_rd_en(mem_rd_en),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .tx_out   (tx_out),
        .tx_busy  (tx_busy)
    );

    initial clk_t = 1'b0;
    always #5 clk_t = ~clk_t;

    // line and busy as seen after each rising edge
    always @(negedge clk_t) begin
        if (t > 0 && t - 1 < MAXC) begin
            line_log[t-1] = tx_out;
            busy_log[t-1] = tx_busy;
        end
    end

    // expected line level after edge k
    function automatic logic exp_line(input int k);
        logic v = 1'b1;
        int   pos;
        for (int i = 0; i < load_edge.size(); i++) begin
            if (k > load_edge[i] && k <= load_edge[i] + FRAME && k < load_end[i]) begin
                pos = (k - load_edge[i] - 1) / CPB;
                if (pos == 0)      v = 1'b0;
                else if (pos <= 8) v = load_byte[i][pos-1];
                else               v = 1'b1;
            end
        end
        return v;
    endfunction

    function automatic logic exp_busy(input int k);
        logic v = 1'b0;
        for (int i = 0; i < load_edge.size(); i++) begin
            if (k >= load_edge[i] && k < load_edge[i] + FRAME && k < load_end[i]) v = 1'b1;
        end
        return v;
    endfunction

    function automatic int line_errs(input int a, input int b);
        int e = 0;
        for (int k = a; k < b; k++) begin
            if (line_log[k] !== exp_line(k) || busy_log[k] !== exp_busy(k)) e++;
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge clk_t);
        #1;
        t++;
    endtask

    // drive one bus cycle, advance the model through that edge, return predicted load data
    task automatic step(input logic wr, input logic rd, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] exp_rd);
        logic pre_busy;
        mem_wr_en = wr;
        mem_rd_en = rd;
        mem_addr  = addr;
        mem_wdata = wdata;
        pre_busy  = (t > 0) ? exp_busy(t - 1) : 1'b0;
        exp_rd    = '0;
        if (rd && addr == A_STAT) exp_rd = {29'b0, m_ovr, m_hold_valid, pre_busy};
        else if (rd && addr == A_DATA) exp_rd = {24'b0, m_last};
        if (m_hold_valid && t >= m_next_load) begin
            m_hold_valid = 1'b0;
            load_edge.push_back(t);
            load_end.push_back(1 << 30);
            load_byte.push_back(m_hold_byte);
            m_next_load = t + FRAME + 1;
        end
        if (rd && addr == A_STAT) m_ovr = 1'b0;
        if (wr && addr == A_DATA) begin
            if (!m_hold_valid) begin
                m_hold_valid = 1'b1;
                m_hold_byte  = wdata[7:0];
                m_last       = wdata[7:0];
            end else begin
                m_ovr = 1'b1;
            end
        end
        tick();
    endtask

    task automatic idle(input int n);
        logic [31:0] e;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 32'h0, e);
    endtask

    // hold reset low for n edges; leaves rst_t low
    task automatic do_reset(input int n);
        mem_wr_en = 1'b0;
        mem_rd_en = 1'b0;
        rst_t     = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (load_end.size() > 0 && load_end[load_end.size()-1] > t)
                load_end[load_end.size()-1] = t;
            m_hold_valid = 1'b0;
            m_ovr        = 1'b0;
            m_last       = 8'h00;
            m_next_load  = 0;
            tick();
        end
    endtask

    // UART receive over logged edges [a,b): sample each bit in its middle
    task automatic decode(input int a, input int b);
        int k;
        logic [7:0] v;
        dec_start.delete();
        dec_byte.delete();
        k = a;
        while (k < b) begin
            if (line_log[k] === 1'b0) begin
                for (int j = 0; j < 8; j++) v[j] = line_log[k + (j + 1) * CPB + CPB / 2];
                dec_start.push_back(k);
                dec_byte.push_back(v);
                k += FRAME;
            end else begin
                k++;
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] e;
        do_reset(3);
        n_checks++;
        if (tx_out !== 1'b1 || tx_busy !== 1'b0 || mem_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got tx=%b busy=%b rdata=%h required tx=1 busy=0 rdata=0",
                     tx_out, tx_busy, mem_rdata);
        end
        rst_t = 1'b1;
        step(1'b0, 1'b1, A_STAT, 32'h0, e);
        n_checks++;
        if (mem_rdata !== 32'h0 || e !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_status: got %h required 0", mem_rdata);
        end
        step(1'b0, 1'b1, A_DATA, 32'h0, e);
        n_checks++;
        if (mem_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h required 0", mem_rdata);
        end
        idle(6);
    endtask

    task automatic test_single_byte();
        logic [31:0] e;
        logic        pat [0:9];
        logic        want;
        int s, errs, bc, p;
        pat = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        s = t;
        step(1'b1, 1'b0, A_DATA, 32'hFFFF_FFA5, e);
        idle(52);
        errs = 0;
        bc   = 0;
        for (int k = 0; k < 50; k++) begin
            p    = (k - 2) / CPB;
            want = (k < 2 || k >= 42) ? 1'b1 : pat[p];
            if (line_log[s + k] !== want) errs++;
            if (busy_log[s + k] === 1'b1) bc++;
        end
        n_checks++;
        if (errs != 0) begin
            n_fail++;
            $display("FAIL single_wave: got %0d wrong line samples required 0", errs);
        end
        n_checks++;
        if (bc != 40) begin
            n_fail++;
            $display("FAIL single_busy: got %0d busy cycles required 40", bc);
        end
        n_checks++;
        if (line_errs(s, s + 50) != 0) begin
            n_fail++;
            $display("FAIL single_model: got %0d mismatches against model required 0", line_errs(s, s + 50));
        end
        step(1'b0, 1'b1, A_DATA, 32'h0, e);
        n_checks++;
        if (mem_rdata !== 32'h0000_00A5 || e !== 32'h0000_00A5) begin
            n_fail++;
            $display("FAIL single_readback: got %h required 000000a5", mem_rdata);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] e;
        int s;
        s = t;
        step(1'b1, 1'b0, A_DATA, 32'h0000_0055, e);
        idle(15);
        step(1'b1, 1'b0, A_DATA, 32'h0000_000F, e);
        idle(100);
        decode(s, s + 110);
        n_checks++;
        if (dec_byte.size() != 2 || dec_byte[0] !== 8'h55 || dec_byte[1] !== 8'h0F) begin
            n_fail++;
            $display("FAIL b2b_bytes: got %0d frames first %h required 2 frames 55 0f",
                     dec_byte.size(), (dec_byte.size() > 0) ? dec_byte[0] : 8'hxx);
        end
        n_checks++;
        if (dec_start.size() != 2 || dec_start[1] - dec_start[0] - FRAME != 1) begin
            n_fail++;
            $display("FAIL b2b_gap: got starts %0d frames gap %0d required 1 idle cycle",
                     dec_start.size(), (dec_start.size() == 2) ? dec_start[1] - dec_start[0] - FRAME : -1);
        end
        n_checks++;
        if (line_errs(s, s + 110) != 0) begin
            n_fail++;
            $display("FAIL b2b_model: got %0d mismatches required 0", line_errs(s, s + 110));
        end
        step(1'b0, 1'b1, A_STAT, 32'h0, e);
        n_checks++;
        if (mem_rdata !== e || mem_rdata[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_status: got %h required %h", mem_rdata, e);
        end
    endtask

    task automatic test_overrun();
        logic [31:0] e;
        logic [7:0]  b1, b2, b3;
        int s;
        b1 = 8'($urandom);
        b2 = 8'($urandom_range(1, 255));
        b3 = 8'($urandom);
        s  = t;
        step(1'b1, 1'b0, A_DATA, {24'h0, b1}, e);
        step(1'b1, 1'b0, A_DATA, {24'h0, b2}, e);
        step(1'b1, 1'b0, A_DATA, {24'h0, b3}, e);
        step(1'b0, 1'b1, A_STAT, 32'h0, e);
        n_checks++;
        if (!(mem_rdata === 32'h6 || mem_rdata === 32'h7) || mem_rdata !== e) begin
            n_fail++;
            $display("FAIL ovr_status: got %h required %h", mem_rdata, e);
        end
        step(1'b0, 1'b1, A_STAT, 32'h0, e);
        n_checks++;
        if (mem_rdata[2] !== 1'b0 || mem_rdata !== e) begin
            n_fail++;
            $display("FAIL ovr_cleared: got %h required %h", mem_rdata, e);
        end
        idle(110);
        decode(s, s + 110);
        n_checks++;
        if (dec_byte.size() != 2 || dec_byte[0] !== b1 || dec_byte[1] !== b2) begin
            n_fail++;
            $display("FAIL ovr_frames: got %0d frames required 2 frames %h %h", dec_byte.size(), b1, b2);
        end
    endtask

    task automatic test_decode();
        logic [31:0] e;
        int s, errs;
        s = t;
        step(1'b1, 1'b0, BASE + 32'd8, 32'h0000_0033, e);
        step(1'b1, 1'b0, A_STAT, 32'hFFFF_FFFF, e);
        step(1'b0, 1'b1, A_DATA, 32'h0, e);
        step(1'b0, 1'b1, BASE + 32'd12, 32'h0, e);
        n_checks++;
        if (mem_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL dec_unmapped: got %h required 0", mem_rdata);
        end
        step(1'b0, 1'b1, A_STAT, 32'h0, e);
        n_checks++;
        if (mem_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL dec_status_idle: got %h required 0", mem_rdata);
        end
        idle(45);
        errs = 0;
        for (int k = s; k < s + 45; k++) if (line_log[k] !== 1'b1 || busy_log[k] !== 1'b0) errs++;
        n_checks++;
        if (errs != 0) begin
            n_fail++;
            $display("FAIL dec_no_frame: got %0d active samples required 0", errs);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] e;
        int s, r, errs;
        s = t;
        step(1'b1, 1'b0, A_DATA, 32'h0000_00C3, e);
        idle(4);
        step(1'b1, 1'b0, A_DATA, 32'h0000_0081, e);
        idle(13);
        r = t;
        do_reset(2);
        n_checks++;
        if (tx_out !== 1'b1 || tx_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs: got tx=%b busy=%b required tx=1 busy=0", tx_out, tx_busy);
        end
        rst_t = 1'b1;
        step(1'b0, 1'b1, A_STAT, 32'h0, e);
        n_checks++;
        if (mem_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_mid_status: got %h required 0", mem_rdata);
        end
        idle(60);
        errs = 0;
        for (int k = r; k < r + 60; k++) if (line_log[k] !== 1'b1 || busy_log[k] !== 1'b0) errs++;
        n_checks++;
        if (errs != 0) begin
            n_fail++;
            $display("FAIL rst_mid_no_frame: got %0d active samples required 0", errs);
        end
        n_checks++;
        if (line_errs(s, r + 60) != 0) begin
            n_fail++;
            $display("FAIL rst_mid_model: got %0d mismatches required 0", line_errs(s, r + 60));
        end
    endtask

    task automatic test_same_cycle_rw();
        logic [31:0] e;
        logic [7:0]  b1, b2;
        int s;
        b1 = 8'($urandom);
        b2 = 8'($urandom_range(1, 254));
        s  = t;
        step(1'b1, 1'b0, A_DATA, {24'h0, b1}, e);
        step(1'b1, 1'b0, A_DATA, {24'h0, b2}, e);
        step(1'b1, 1'b1, A_DATA, {24'h0, b2 + 8'd1}, e);
        n_checks++;
        if (mem_rdata !== {24'h0, b2} || mem_rdata !== e) begin
            n_fail++;
            $display("FAIL rw_data_pre: got %h required %h", mem_rdata, {24'h0, b2});
        end
        step(1'b1, 1'b1, A_STAT, 32'hFFFF_FFFF, e);
        n_checks++;
        if (mem_rdata[2] !== 1'b1 || mem_rdata !== e) begin
            n_fail++;
            $display("FAIL rw_ovr_set: got %h required %h", mem_rdata, e);
        end
        step(1'b0, 1'b1, A_STAT, 32'h0, e);
        n_checks++;
        if (mem_rdata[2] !== 1'b0 || mem_rdata !== e) begin
            n_fail++;
            $display("FAIL rw_ovr_clear: got %h required %h", mem_rdata, e);
        end
        idle(100);
        decode(s, s + 100);
        n_checks++;
        if (dec_byte.size() != 2 || dec_byte[0] !== b1 || dec_byte[1] !== b2) begin
            n_fail++;
            $display("FAIL rw_frames: got %0d frames required 2 frames %h %h", dec_byte.size(), b1, b2);
        end
    endtask

    task automatic test_random();
        logic [31:0] e, addr;
        logic        wr, rd;
        int a, b, sel, nb, rd_bad, idx;
        logic [7:0] want [$];
        a = t;
        rd_bad = 0;
        for (int i = 0; i < 400; i++) begin
            wr  = ($urandom_range(0, 99) < 15);
            rd  = ($urandom_range(0, 99) < 25);
            sel = $urandom_range(0, 7);
            addr = (sel < 4) ? A_DATA : (sel < 6) ? A_STAT : (sel == 6) ? BASE + 32'd8 : BASE - 32'd4;
            step(wr, rd, addr, $urandom, e);
            if (rd) begin
                n_checks++;
                if (mem_rdata !== e) begin
                    n_fail++;
                    rd_bad++;
                    if (rd_bad < 10)
                        $display("FAIL rand_read: addr %h got %h required %h", addr, mem_rdata, e);
                end
            end
        end
        idle(100);
        b = t - 2;
        n_checks++;
        if (line_errs(a, b) != 0) begin
            n_fail++;
            $display("FAIL rand_line: got %0d mismatches required 0", line_errs(a, b));
        end
        for (int i = 0; i < load_edge.size(); i++)
            if (load_edge[i] >= a && load_edge[i] + FRAME < b) want.push_back(load_byte[i]);
        decode(a, b);
        nb = 0;
        for (int i = 0; i < dec_byte.size(); i++) begin
            idx = i;
            if (idx >= want.size() || dec_byte[i] !== want[idx]) nb++;
        end
        n_checks++;
        if (nb != 0 || dec_byte.size() != want.size()) begin
            n_fail++;
            $display("FAIL rand_bytes: got %0d frames %0d wrong required %0d frames", dec_byte.size(), nb, want.size());
        end
    endtask

    initial begin
        rst_t     = 1'b0;
        mem_wr_en = 1'b0;
        mem_rd_en = 1'b0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_overrun();
        test_decode();
        test_reset_mid_frame();
        test_same_cycle_rw();
        test_random();
        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
